// File: rtl/jk_pkg.sv
// Shared types for the JK bank driver: sequencer states and per-bit {j,k} excitation codes.
package jk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StWait,
    StCheck
  } state_e;

  // Excitation codes packed as {j, k}
  localparam logic [1:0] ExHold   = 2'b00;
  localparam logic [1:0] ExSet    = 2'b10;
  localparam logic [1:0] ExReset  = 2'b01;
  localparam logic [1:0] ExToggle = 2'b11;

endpackage

// File: rtl/jk_bank_driver_if.sv
// Target handshake plus JK bank wiring between the driver (master) and the bank/producer side.
interface jk_bank_driver_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             done;
  logic             err;

  modport master (
    input  tgt_valid,
    input  tgt_data,
    input  q_in,
    output tgt_ready,
    output j,
    output k,
    output done,
    output err
  );

  modport slave (
    output tgt_valid,
    output tgt_data,
    output q_in,
    input  tgt_ready,
    input  j,
    input  k,
    input  done,
    input  err
  );

endinterface

// File: rtl/jk_excite.sv
// Combinational excitation for one JK flop: picks {j,k} that moves q toward t.
module jk_excite
  import jk_pkg::*;
#(
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

  logic [1:0] ex;

  always_comb begin
    ex = ExHold;
    if (q != t) begin
      if (USE_TOGGLE) begin
        ex = ExToggle;
      end else if (t) begin
        ex = ExSet;
      end else begin
        ex = ExReset;
      end
    end
  end

  assign {j, k} = ex;

endmodule

// File: rtl/msjk.sv
// Master-slave JK flop: master samples J/K on the rising edge, slave follows on the falling edge.
module msjk (
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic mq,
  output logic sq
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mq <= 1'b0;
    end else begin
      case ({j, k})
        2'b10:   mq <= 1'b1;
        2'b01:   mq <= 1'b0;
        2'b11:   mq <= ~sq;
        default: mq <= mq;
      endcase
    end
  end

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      sq <= 1'b0;
    end else begin
      sq <= mq;
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flops to a requested word: pulse excitation, settle, read back, retry.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned MAX_RETRY  = 3,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input logic              clk,
  input logic              rst,
  jk_bank_driver_if.master bus
);

  state_e           state_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic [3:0]       settle_q;
  logic [2:0]       retry_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH-1:0] ex_tgt;
  logic [WIDTH-1:0] ex_j;
  logic [WIDTH-1:0] ex_k;

  // Fresh targets excite from tgt_data; retries excite from the captured target.
  assign ex_tgt = (state_q == StIdle) ? bus.tgt_data : tgt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    jk_excite #(
      .USE_TOGGLE(USE_TOGGLE)
    ) u_excite (
      .q(bus.q_in[i]),
      .t(ex_tgt[i]),
      .j(ex_j[i]),
      .k(ex_k[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tgt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      settle_q <= '0;
      retry_q  <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          j_q <= '0;
          k_q <= '0;
          if (bus.tgt_valid && ready_q) begin
            tgt_q   <= bus.tgt_data;
            j_q     <= ex_j;
            k_q     <= ex_k;
            retry_q <= '0;
            ready_q <= 1'b0;
            state_q <= StDrive;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StDrive: begin
          j_q      <= '0;
          k_q      <= '0;
          // WAIT spans SETTLE edges counting down to zero.
          settle_q <= 4'(SETTLE - 1);
          state_q  <= StWait;
        end
        StWait: begin
          if (settle_q == '0) begin
            state_q <= StCheck;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        StCheck: begin
          if (bus.q_in == tgt_q) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else if (retry_q < 3'(MAX_RETRY)) begin
            retry_q <= retry_q + 3'd1;
            j_q     <= ex_j;
            k_q     <= ex_k;
            state_q <= StDrive;
          end else begin
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tgt_ready = ready_q;
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  done_err_exclusive: assert property (@(posedge clk) disable iff (rst) !(done_q && err_q));

endmodule
